alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
(no parameters; all datapaths fixed at 4 bits)
REQ-001 clk  input  1  single clock; all state updates on rising edge.
REQ-002 rst  input  1  synchronous, active-high reset, sampled on rising edge of clk.
REQ-003 req0_valid  input  1  port 0 request pending.
REQ-004 req0_a, req0_b  input  4 each  port 0 operands.
REQ-005 req0_sel  input  3  port 0 opcode.
REQ-006 req0_ready  output  1  port 0 request accepted this cycle.
REQ-007 req1_valid, req1_a, req1_b, req1_sel, req1_ready: same as REQ-003..REQ-006 for port 1.
REQ-008 rsp_valid  output  1  result available.
REQ-009 rsp_data  output  4  result value.
REQ-010 rsp_id  output  1  port that issued the result (0/1).
REQ-011 rsp_ready  input  1  consumer takes result this cycle.
REQ-012 busy  output  1  high whenever state is not IDLE.
REQ-013 op_count  output  8  total results delivered, wraps 255->0.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; state SHALL change only on clk rising edge.
REQ-015 IDLE: if either valid is high, grant one port, assert that port's ready combinationally in the same cycle, latch its a/b/sel/id, go to EXEC; else stay IDLE.
REQ-016 reqN_ready SHALL be high only in IDLE and only for the granted port; never both high in one cycle.
REQ-017 Arbitration: one valid -> grant it; both valid -> grant the port not granted last (round-robin); last_grant SHALL update only on an accept.
REQ-018 EXEC: compute result from latched operands, register into rsp_data/rsp_id, set rsp_valid, go to RESP (exactly one cycle).
REQ-019 Opcode semantics, all results truncated to 4 bits: 000 -> 0; 001 -> a<<1; 010 -> b<<1; 011 -> (~a)^(~b); 100 -> a&~b; 101 -> a|b; 110 -> (~a)+b mod 16; 111 -> 1.
REQ-020 RESP: rsp_valid, rsp_data, rsp_id SHALL hold stable until rsp_ready is high; on that cycle rsp_valid clears next edge, op_count increments, state returns to IDLE.
REQ-021 Latency: request accepted at edge N -> rsp_valid high after edge N+2 (visible during cycle N+2 to N+3 window); minimum issue interval 3 cycles.
REQ-022 rsp_ready high while rsp_valid low SHALL have no effect.
REQ-023 Requester operand changes after accept SHALL not affect the in-flight result.
REQ-024 op_count SHALL wrap 255 -> 0 with no other side effect.
REQ-025 New requests arriving in EXEC/RESP SHALL wait (ready low) and are not dropped if valid stays high.

Reset
REQ-026 On rst: state=IDLE, rsp_valid=0, rsp_data=0, rsp_id=0, op_count=0, last_grant=1 (port 0 wins first tie), busy=0.
REQ-027 rst SHALL override all activity, including mid-EXEC or mid-RESP; in-flight result is discarded and not counted.
REQ-028 During rst cycle, req0_ready and req1_ready SHALL be 0.

Verification
REQ-029 Port 0 only, a=4'h3, b=4'h5, sel=110 -> req0_ready 1 cycle, rsp_data=4'h1, rsp_id=0, rsp_valid two edges later, op_count=1 after rsp_ready.
REQ-030 Both valid from reset, port0 sel=101 a=4'h9 b=4'h6, port1 sel=001 a=4'hC -> port 0 first (rsp 4'hF, id 0), then port 1 (rsp 4'h8, id 1); next tie goes to port 0.
REQ-031 Backpressure: rsp_ready low 5 cycles on sel=100 a=4'hF b=4'h3 -> rsp_data=4'hC held stable, both readys low, busy=1, then released on rsp_ready.
REQ-032 Sweep all 8 sels with a=4'hA, b=4'h6 -> results 0,4,C,C,8,E,B,1 in order.
REQ-033 Assert rst during RESP -> rsp_valid=0, op_count unchanged at 0, next request served normally.
REQ-034 Run 256 transactions -> op_count reads 0 after the 256th rsp_ready handshake.

Source files
------------

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter in front of a 4-bit ALU.
// Each request runs IDLE -> EXEC -> RESP, and the result is held until the consumer takes it.
module alu_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [2:0] req0_sel,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [2:0] req1_sel,
    output logic       req1_ready,
    output logic       rsp_valid,
    output logic [3:0] rsp_data,
    output logic       rsp_id,
    input  logic       rsp_ready,
    output logic       busy,
    output logic [7:0] op_count
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t     state_q;
    logic       last_q;
    logic [3:0] a_q, b_q;
    logic [2:0] sel_q;
    logic       id_q;
    logic       rsp_valid_q;
    logic [3:0] rsp_data_q;
    logic       rsp_id_q;
    logic [7:0] cnt_q;

    logic       grant_vld_d;
    logic       grant_id_d;
    logic [3:0] alu_d;

    // On a tie, grant the port that did not win the last accept.
    always_comb begin
        grant_vld_d = (state_q == IDLE) && (req0_valid || req1_valid);
        grant_id_d  = (req0_valid && req1_valid) ? ~last_q : req1_valid;
        req0_ready  = grant_vld_d && !grant_id_d && !rst;
        req1_ready  = grant_vld_d &&  grant_id_d && !rst;
    end

    always_comb begin
        alu_d = 4'h0;
        case (sel_q)
            3'd0: alu_d = 4'h0;
            3'd1: alu_d = a_q << 1;
            3'd2: alu_d = b_q << 1;
            3'd3: alu_d = (~a_q) ^ (~b_q);
            3'd4: alu_d = a_q & ~b_q;
            3'd5: alu_d = a_q | b_q;
            3'd6: alu_d = (~a_q) + b_q;
            3'd7: alu_d = 4'h1;
            default: alu_d = 4'h0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 4'h0;
            rsp_id_q    <= 1'b0;
            cnt_q       <= 8'h00;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_vld_d) begin
                        a_q     <= grant_id_d ? req1_a   : req0_a;
                        b_q     <= grant_id_d ? req1_b   : req0_b;
                        sel_q   <= grant_id_d ? req1_sel : req0_sel;
                        id_q    <= grant_id_d;
                        last_q  <= grant_id_d;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_d;
                    rsp_id_q    <= id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cnt_q       <= cnt_q + 8'd1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_id    = rsp_id_q;
    assign busy      = (state_q != IDLE);
    assign op_count  = cnt_q;
endmodule
